exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//   MEM-stage exception controller and the producer side of the CP0 exception interface.
//   Synchronises raw interrupt lines into int_o, which feeds the CP0 int_i input.
//   Prioritises per-instruction exception flags plus pending interrupts into exccode_o,
//   and drives pc_o, in_delay_o and exc_badvaddr_o with it.
//   Suppresses new exceptions while the pipeline drains after a flush.
// PARAMETERS
//   SYNC_STAGES  2  flops in each interrupt-line synchroniser (legal range 2..3)
//   FLUSH_HOLD   2  cycles exccode_o is forced to EXC_NONE after any non-NONE code (legal range 1..7)
// PORTS
//   cpu_clk_50M     in   1   sole clock; all flops on rising edge
//   cpu_rst         in   1   asynchronous, active-high reset
//   ext_int_i       in   6   raw hardware interrupt lines, asynchronous to cpu_clk_50M
//   mem_valid_i     in   1   MEM stage holds a real (non-bubble) instruction
//   mem_pc_i        in   32  PC of the MEM instruction
//   mem_in_delay_i  in   1   MEM instruction sits in a branch delay slot
//   adel_if_i       in   1   fetch address error (PC misaligned)
//   ri_i            in   1   reserved instruction
//   ov_i            in   1   arithmetic overflow
//   sys_i           in   1   SYSCALL
//   bp_i            in   1   BREAK
//   adel_i          in   1   load address error
//   ades_i          in   1   store address error
//   eret_i          in   1   ERET in MEM
//   mem_addr_i      in   32  data address of the MEM load/store
//   status_i        in   32  CP0 Status (IE=bit0, EXL=bit1, IM=bits15:8)
//   cause_i         in   32  CP0 Cause (IP=bits15:8)
//   int_o           out  6   synchronised interrupt lines to CP0 int_i
//   exccode_o       out  5   exception code to CP0
//   exc_badvaddr_o  out  32  faulting address to CP0
//   pc_o            out  32  mem_pc_i pass-through
//   in_delay_o      out  1   mem_in_delay_i pass-through
// BEHAVIOUR
//   Codes: INT=5'h00, ADEL=5'h04, ADES=5'h05, SYS=5'h08, BP=5'h09, RI=5'h0A, OV=5'h0C,
//     NONE=5'h10, ERET=5'h11.
//   Reset (async assert, sync release) clears all synchroniser flops and the hold counter.
//     State returns to RUN immediately on assert.
//     Output values in reset: int_o=0, exccode_o=NONE, exc_badvaddr_o=0, pc_o=0, in_delay_o=0.
//   Synchroniser: SYNC_STAGES flops per line; int_o is the last stage (level, not edge).
//     Latency from ext_int_i to int_o is SYNC_STAGES cycles.
//   int_pending = IE & ~EXL & |(cause_i[15:8] & status_i[15:8]).
//     Bits 9:8 are software interrupts; bits 15:10 are hardware interrupts mirrored by CP0 from int_o.
//   exccode_o is combinational from the current inputs and the state; it is not registered.
//     It is NONE whenever mem_valid_i=0, the state is HOLD, or no condition is true.
//   Priority, highest first: INT, ADEL(fetch), RI, OV, SYS, BP, ADEL(data), ADES, ERET.
//   exc_badvaddr_o selection:
//     mem_pc_i for fetch ADEL;
//     mem_addr_i for data ADEL/ADES;
//     otherwise 0.
//   pc_o = mem_pc_i and in_delay_o = mem_in_delay_i, valid whenever exccode_o != NONE.
//   FSM RUN/HOLD:
//     RUN -> HOLD on any cycle with exccode_o != NONE (ERET included); the counter loads FLUSH_HOLD-1.
//     HOLD decrements the counter each cycle and returns to RUN in the cycle after the counter reads 0.
//     FLUSH_HOLD=1 gives exactly one forced-NONE cycle.
//   Simultaneous flags resolve by priority only: one code per cycle and no queueing.
//     Lower-priority flags are dropped, because the flush discards the instruction.
//   An interrupt arriving during HOLD is not lost.
//     It stays pending through cause_i and is taken in the first RUN cycle with mem_valid_i=1.
//   mem_valid_i=0 never raises an exception, including an interrupt.
//     An interrupt waits for a valid instruction so that the EPC is correct.
//   Reset asserted in HOLD: the counter clears and no stale code is emitted after release.
// TESTING
//   1. ext_int_i[0] rises, IE=1, EXL=0, IM[10]=1, mem_valid_i=1:
//      int_o[0]=1 after 2 cycles; with cause_i[10] fed back, exccode_o=5'h00 and pc_o=mem_pc_i.
//   2. ri_i=1 and ov_i=1 in the same cycle: exccode_o=5'h0A; the next 2 cycles are NONE despite new flags;
//      ov_i=1 in the 3rd cycle gives 5'h0C.
//   3. adel_i=1, mem_addr_i=32'h8000_0003: exccode_o=5'h04 and exc_badvaddr_o=32'h8000_0003;
//      fetch ADEL with pc 32'hBFC0_0002 gives exc_badvaddr_o=32'hBFC0_0002.
//   4. eret_i=1 with no other flag: exccode_o=5'h11 and FSM enters HOLD;
//      with EXL=1 a pending interrupt is not taken.
//   5. Interrupt pending while mem_valid_i=0 for 3 cycles: exccode_o=NONE;
//      on the first valid cycle exccode_o=5'h00 and in_delay_o equals mem_in_delay_i.
//   6. Assert cpu_rst mid-HOLD off a clock edge: exccode_o=NONE and int_o=0 immediately;
//      after release a flag is accepted on the first valid cycle.

Source files
------------

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl -- MEM-stage exception controller, producer side of the CP0
// exception interface.
//
// Synchronises the raw hardware interrupt lines into int_o (mirrored by CP0
// into Cause.IP[15:10]). Resolves the per-instruction exception flags and any
// pending interrupt into a single exception code for the instruction in MEM.
// Once a code is emitted, new exceptions are suppressed while the pipeline
// drains after the flush.
//
// Parameters
//   SYNC_STAGES  flops per interrupt-line synchroniser (2..3)
//   FLUSH_HOLD   forced-NONE cycles after any non-NONE code (1..7)
//
// Ports
//   cpu_clk_50M     in   1   clock, rising edge
//   cpu_rst         in   1   asynchronous active-high reset
//   ext_int_i       in   6   raw interrupt lines (asynchronous)
//   mem_valid_i     in   1   MEM holds a real instruction
//   mem_pc_i        in   32  PC of the MEM instruction
//   mem_in_delay_i  in   1   MEM instruction is in a branch delay slot
//   adel_if_i       in   1   fetch address error
//   ri_i            in   1   reserved instruction
//   ov_i            in   1   arithmetic overflow
//   sys_i           in   1   SYSCALL
//   bp_i            in   1   BREAK
//   adel_i          in   1   load address error
//   ades_i          in   1   store address error
//   eret_i          in   1   ERET in MEM
//   mem_addr_i      in   32  data address of the MEM load/store
//   status_i        in   32  CP0 Status (IE=0, EXL=1, IM=15:8)
//   cause_i         in   32  CP0 Cause (IP=15:8)
//   int_o           out  6   synchronised interrupt lines
//   exccode_o       out  5   exception code (combinational)
//   exc_badvaddr_o  out  32  faulting address
//   pc_o            out  32  mem_pc_i pass-through
//   in_delay_o      out  1   mem_in_delay_i pass-through
// -----------------------------------------------------------------------------
module exc_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FLUSH_HOLD  = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [5:0]  ext_int_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        sys_i,
    input  logic        bp_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    output logic [5:0]  int_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] exc_badvaddr_o,
    output logic [31:0] pc_o,
    output logic        in_delay_o
);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ERET = 5'h11;

    // Counter is loaded with FLUSH_HOLD-1 so that HOLD lasts FLUSH_HOLD cycles.
    localparam logic [2:0] HOLD_LOAD = 3'(FLUSH_HOLD - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;

    logic        int_pending;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;

    // Only IE, EXL and the IM/IP bytes matter here.
    logic unused_ok;
    assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    // ---------------------------------------------------------------------
    // Interrupt synchroniser: shift each line through SYNC_STAGES flops.
    // ---------------------------------------------------------------------
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ext_int_i};
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign int_o = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Exception prioritisation (combinational).
    // ---------------------------------------------------------------------
    assign int_pending = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

    always_comb begin
        exc_code     = EXC_NONE;
        exc_badvaddr = '0;
        // Bubbles never raise anything, so an interrupt waits for a real
        // instruction and EPC points at it.
        if (!cpu_rst && (state_q == ST_RUN) && mem_valid_i) begin
            if (int_pending) begin
                exc_code = EXC_INT;
            end else if (adel_if_i) begin
                exc_code     = EXC_ADEL;
                exc_badvaddr = mem_pc_i;
            end else if (ri_i) begin
                exc_code = EXC_RI;
            end else if (ov_i) begin
                exc_code = EXC_OV;
            end else if (sys_i) begin
                exc_code = EXC_SYS;
            end else if (bp_i) begin
                exc_code = EXC_BP;
            end else if (adel_i) begin
                exc_code     = EXC_ADEL;
                exc_badvaddr = mem_addr_i;
            end else if (ades_i) begin
                exc_code     = EXC_ADES;
                exc_badvaddr = mem_addr_i;
            end else if (eret_i) begin
                exc_code = EXC_ERET;
            end
        end
    end

    assign exccode_o      = exc_code;
    assign exc_badvaddr_o = exc_badvaddr;
    assign pc_o           = cpu_rst ? 32'd0 : mem_pc_i;
    assign in_delay_o     = cpu_rst ? 1'b0 : mem_in_delay_i;

    // ---------------------------------------------------------------------
    // RUN/HOLD flush suppression FSM.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (exc_code != EXC_NONE) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int FLUSH_HOLD  = 2;
    localparam logic [4:0] NONE = 5'h10;

    logic        cpu_clk_50M;
    logic        cpu_rst;
    logic [5:0]  ext_int_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delay_i;
    logic        adel_if_i, ri_i, ov_i, sys_i, bp_i, adel_i, ades_i, eret_i;
    logic [31:0] mem_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [5:0]  int_o;
    logic [4:0]  exccode_o;
    logic [31:0] exc_badvaddr_o;
    logic [31:0] pc_o;
    logic        in_delay_o;

    exc_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .FLUSH_HOLD (FLUSH_HOLD)
    ) dut (
        .cpu_clk_50M   (cpu_clk_50M),
        .cpu_rst       (cpu_rst),
        .ext_int_i     (ext_int_i),
        .mem_valid_i   (mem_valid_i),
        .mem_pc_i      (mem_pc_i),
        .mem_in_delay_i(mem_in_delay_i),
        .adel_if_i     (adel_if_i),
        .ri_i          (ri_i),
        .ov_i          (ov_i),
        .sys_i         (sys_i),
        .bp_i          (bp_i),
        .adel_i        (adel_i),
        .ades_i        (ades_i),
        .eret_i        (eret_i),
        .mem_addr_i    (mem_addr_i),
        .status_i      (status_i),
        .cause_i       (cause_i),
        .int_o         (int_o),
        .exccode_o     (exccode_o),
        .exc_badvaddr_o(exc_badvaddr_o),
        .pc_o          (pc_o),
        .in_delay_o    (in_delay_o)
    );

    initial begin
        cpu_clk_50M = 1'b0;
        forever #5 cpu_clk_50M = ~cpu_clk_50M;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: history of sampled interrupt lines (newest
    // first) and number of forced-NONE cycles still owed after a flush.
    logic [5:0] int_hist[$];
    int         hold_left = 0;
    bit         fb = 1'b0;   // mirror expected int_o into cause_i[15:10]

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_int();
        if (int_hist.size() >= SYNC_STAGES) return int_hist[SYNC_STAGES-1];
        return 6'd0;
    endfunction

    function automatic void ref_exc(output logic [4:0] code, output logic [31:0] bad);
        logic [4:0] codes [9];
        logic [8:0] flags;
        logic       pend;
        code = NONE;
        bad  = 32'd0;
        if (cpu_rst || hold_left > 0 || !mem_valid_i) return;
        pend  = status_i[0] && !status_i[1] && ((cause_i[15:8] & status_i[15:8]) != 8'd0);
        // index 8 = highest priority
        codes = '{5'h11, 5'h05, 5'h04, 5'h09, 5'h08, 5'h0C, 5'h0A, 5'h04, 5'h00};
        flags = {pend, adel_if_i, ri_i, ov_i, sys_i, bp_i, adel_i, ades_i, eret_i};
        for (int i = 8; i >= 0; i--) begin
            if (flags[i]) begin
                code = codes[i];
                if (i == 7) bad = mem_pc_i;
                else if (i == 2 || i == 1) bad = mem_addr_i;
                break;
            end
        end
    endfunction

    task automatic tick(input string tag);
        logic [4:0]  ec;
        logic [31:0] eb;
        if (fb) cause_i[15:10] = exp_int();
        #1;
        ref_exc(ec, eb);
        chk({tag, ":int"},  {26'd0, int_o},     {26'd0, exp_int()});
        chk({tag, ":code"}, {27'd0, exccode_o}, {27'd0, ec});
        chk({tag, ":bad"},  exc_badvaddr_o,     eb);
        chk({tag, ":pc"},   pc_o,               cpu_rst ? 32'd0 : mem_pc_i);
        chk({tag, ":dly"},  {31'd0, in_delay_o}, {31'd0, (cpu_rst ? 1'b0 : mem_in_delay_i)});
        @(posedge cpu_clk_50M);
        if (cpu_rst) begin
            int_hist.delete();
            hold_left = 0;
        end else begin
            int_hist.push_front(ext_int_i);
            if (int_hist.size() > SYNC_STAGES) void'(int_hist.pop_back());
            if (hold_left > 0) hold_left--;
            else if (ec != NONE) hold_left = FLUSH_HOLD;
        end
        #1;
    endtask

    task automatic clear_flags();
        adel_if_i = 0; ri_i = 0; ov_i = 0; sys_i = 0;
        bp_i = 0; adel_i = 0; ades_i = 0; eret_i = 0;
    endtask

    initial begin
        cpu_rst = 1'b1;
        ext_int_i = '0; mem_valid_i = 0; mem_pc_i = '0; mem_in_delay_i = 0;
        mem_addr_i = '0; status_i = '0; cause_i = '0;
        clear_flags();

        // Reset state
        tick("rst0");
        tick("rst1");
        #3 cpu_rst = 1'b0;
        tick("rel");

        // 1: hardware interrupt through the synchroniser and Cause feedback
        status_i = 32'h0000_0401; mem_valid_i = 1; mem_pc_i = 32'h8000_1000;
        ext_int_i = 6'b000001; fb = 1;
        tick("t1a");
        tick("t1b");
        cause_i[15:10] = exp_int();
        #1 chk("t1_int0", {31'd0, int_o[0]}, 32'd1);
        chk("t1_code", {27'd0, exccode_o}, 32'h00);
        chk("t1_pc", pc_o, 32'h8000_1000);
        tick("t1c");
        fb = 0; ext_int_i = '0; cause_i = '0; status_i = '0;
        tick("t1h0");
        tick("t1h1");

        // 2: RI beats OV, then flush hold, then OV
        ri_i = 1; ov_i = 1;
        #1 chk("t2_ri", {27'd0, exccode_o}, 32'h0A);
        tick("t2a");
        tick("t2h0");
        tick("t2h1");
        ri_i = 0;
        #1 chk("t2_ov", {27'd0, exccode_o}, 32'h0C);
        tick("t2b");
        clear_flags();
        tick("t2h2");
        tick("t2h3");

        // 3: data and fetch address errors
        adel_i = 1; mem_addr_i = 32'h8000_0003;
        #1 chk("t3_adel", {27'd0, exccode_o}, 32'h04);
        chk("t3_bad", exc_badvaddr_o, 32'h8000_0003);
        tick("t3a");
        clear_flags();
        tick("t3h0");
        tick("t3h1");
        adel_if_i = 1; mem_pc_i = 32'hBFC0_0002;
        #1 chk("t3_badif", exc_badvaddr_o, 32'hBFC0_0002);
        tick("t3b");
        clear_flags();
        tick("t3h2");
        tick("t3h3");

        // 4: ERET enters HOLD; EXL masks a pending interrupt
        eret_i = 1;
        #1 chk("t4_eret", {27'd0, exccode_o}, 32'h11);
        tick("t4a");
        eret_i = 0; sys_i = 1;
        #1 chk("t4_hold", {27'd0, exccode_o}, {27'd0, NONE});
        tick("t4h0");
        tick("t4h1");
        sys_i = 0;
        status_i = 32'h0000_0103; cause_i = 32'h0000_0100;
        #1 chk("t4_exl", {27'd0, exccode_o}, {27'd0, NONE});
        tick("t4b");

        // 5: pending interrupt waits for a valid instruction
        status_i = 32'h0000_0101; mem_valid_i = 0;
        tick("t5a");
        tick("t5b");
        tick("t5c");
        mem_valid_i = 1; mem_in_delay_i = 1; mem_pc_i = 32'h8000_2004;
        #1 chk("t5_int", {27'd0, exccode_o}, 32'h00);
        chk("t5_dly", {31'd0, in_delay_o}, 32'd1);
        tick("t5d");
        status_i = '0; cause_i = '0; mem_in_delay_i = 0;
        tick("t5h0");
        tick("t5h1");

        // 6: reset asserted mid-HOLD, off a clock edge
        ext_int_i = 6'h3F;
        tick("t6p0");
        tick("t6p1");
        sys_i = 1;
        tick("t6a");
        sys_i = 0;
        #3 cpu_rst = 1'b1;
        hold_left = 0;
        int_hist.delete();
        #1 chk("t6_code", {27'd0, exccode_o}, {27'd0, NONE});
        chk("t6_int", {26'd0, int_o}, 32'd0);
        tick("t6r");
        #3 cpu_rst = 1'b0;
        ext_int_i = '0; ov_i = 1;
        #1 chk("t6_after", {27'd0, exccode_o}, 32'h0C);
        tick("t6b");
        clear_flags();

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            mem_valid_i    = ($urandom_range(0, 3) != 0);
            mem_pc_i       = $urandom;
            mem_addr_i     = $urandom;
            mem_in_delay_i = $urandom_range(0, 1) == 1;
            ext_int_i      = 6'($urandom);
            status_i       = $urandom;
            cause_i        = $urandom & (($urandom_range(0, 2) == 0) ? 32'h0000_FF00 : 32'h0);
            fb             = ($urandom_range(0, 1) == 1);
            adel_if_i      = ($urandom_range(0, 9) == 0);
            ri_i           = ($urandom_range(0, 9) == 0);
            ov_i           = ($urandom_range(0, 9) == 0);
            sys_i          = ($urandom_range(0, 9) == 0);
            bp_i           = ($urandom_range(0, 9) == 0);
            adel_i         = ($urandom_range(0, 9) == 0);
            ades_i         = ($urandom_range(0, 9) == 0);
            eret_i         = ($urandom_range(0, 9) == 0);
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
